unified_mem_arbiter: RTL and testbench

- Shares one single-ported unified memory between the fetch stage (instruction reads) and the memory stage (data loads/stores) of the pipelined core.
- Serializes the two requesters and drives a req/ack memory handshake with variable wait states.
- Returns per-requester ready/error pulses and a fetch-stall indication for the hazard logic.
- Sits between the pipeline's stage interfaces and the memory model/bus.

---
 rtl/unified_mem_arbiter_pkg.sv | 7 +
 rtl/unified_mem_arbiter_if.sv | 32 +++
 rtl/unified_mem_arbiter_wait_timer.sv | 17 +
 rtl/unified_mem_arbiter.sv | 92 +++++++++
 tb/tb_unified_mem_arbiter.sv | 147 ++++++++++++++
 5 files changed

// File: rtl/unified_mem_arbiter_pkg.sv
// mem_arb_pkg: shared types and constants for the unified memory arbiter.
package mem_arb_pkg;
    typedef enum logic [2:0] {IDLE, BUSY_I, BUSY_D, RESP_I, RESP_D} arb_state_t;
    localparam int CNT_W = 8;
    localparam logic GNT_I = 1'b0;
    localparam logic GNT_D = 1'b1;
endpackage

// File: rtl/unified_mem_arbiter_if.sv
// unified_mem_arbiter_if: fetch, data and memory-bus signals of the arbiter.
interface unified_mem_arbiter_if #(parameter int AW = 32, parameter int DW = 32);
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          if_ready;
    logic          if_err;
    logic          stall_if;
    logic          dm_req;
    logic          dm_we;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata;
    logic [DW-1:0] dm_rdata;
    logic          dm_ready;
    logic          dm_err;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ack;
    modport master (
        input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_ack,
        output if_rdata, if_ready, if_err, stall_if, dm_rdata, dm_ready, dm_err,
               mem_req, mem_we, mem_addr, mem_wdata
    );
    modport slave (
        output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_ack,
        input  if_rdata, if_ready, if_err, stall_if, dm_rdata, dm_ready, dm_err,
               mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/unified_mem_arbiter_wait_timer.sv
// wait_timer: counts BUSY cycles and flags the last one allowed before abort.
module wait_timer
    import mem_arb_pkg::*;
#(parameter int TIMEOUT = 16) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    always_comb cnt_d = clr ? '0 : en ? cnt_q + 1'b1 : cnt_q;
    always_ff @(posedge clk or negedge rst)
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    assign expired = cnt_q == CNT_W'(TIMEOUT - 1);
endmodule

// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter: serializes fetch and data accesses onto one req/ack memory port.
module unified_mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 16
) (
    input logic clk,
    input logic rst,
    unified_mem_arbiter_if.master bus
);
    arb_state_t    state_q, state_d;
    logic          mem_req_q, mem_req_d, mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic [DW-1:0] if_rdata_q, if_rdata_d, dm_rdata_q, dm_rdata_d, rd;
    logic          if_err_q, if_err_d, dm_err_q, dm_err_d;
    logic          gnt, busy, expired;
    assign busy = state_q == BUSY_I || state_q == BUSY_D;
    assign gnt  = bus.dm_req ? GNT_D : GNT_I;
    assign rd   = bus.mem_ack && !mem_we_q ? bus.mem_rdata : '0;
    wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk(clk), .rst(rst), .clr(!busy), .en(busy), .expired(expired)
    );
    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;
        if_err_d    = if_err_q;
        dm_err_d    = dm_err_q;
        case (state_q)
            IDLE: if (bus.dm_req || bus.if_req) begin
                state_d     = gnt == GNT_D ? BUSY_D : BUSY_I;
                mem_req_d   = 1'b1;
                mem_we_d    = gnt == GNT_D && bus.dm_we;
                mem_addr_d  = gnt == GNT_D ? bus.dm_addr : bus.if_addr;
                mem_wdata_d = gnt == GNT_D ? bus.dm_wdata : '0;
            end
            BUSY_I: if (bus.mem_ack || expired) begin
                state_d    = RESP_I;
                mem_req_d  = 1'b0;
                if_rdata_d = rd;
                if_err_d   = !bus.mem_ack;
            end
            BUSY_D: if (bus.mem_ack || expired) begin
                state_d    = RESP_D;
                mem_req_d  = 1'b0;
                dm_rdata_d = rd;
                dm_err_d   = !bus.mem_ack;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
            if_err_q    <= 1'b0;
            dm_err_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
            if_err_q    <= if_err_d;
            dm_err_q    <= dm_err_d;
        end
    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.dm_rdata  = dm_rdata_q;
    assign bus.if_err    = if_err_q;
    assign bus.dm_err    = dm_err_q;
    assign bus.if_ready  = state_q == RESP_I;
    assign bus.dm_ready  = state_q == RESP_D;
    assign bus.stall_if  = bus.if_req && !bus.if_ready;
endmodule

// File: tb/tb_unified_mem_arbiter.sv
// tb_unified_mem_arbiter: directed vector table plus timeout/reset/spurious-ack sequences.
module tb_unified_mem_arbiter;
    typedef struct {
        logic        dm, we;
        logic [31:0] daddr, wdata;
        logic        ifr;
        logic [31:0] iaddr;
        int          dly;
        logic [31:0] rdata;
        logic        exp_d, exp_we;
        logic [31:0] exp_addr, exp_wdata, exp_rdata;
    } vec_t;

    logic clk, rst;
    int tests, fails;
    vec_t v[6];

    unified_mem_arbiter_if #(.AW(32), .DW(32)) a();
    unified_mem_arbiter_if #(.AW(32), .DW(32)) b();
    unified_mem_arbiter #(.AW(32), .DW(32), .TIMEOUT(16)) dut  (.clk(clk), .rst(rst), .bus(a));
    unified_mem_arbiter #(.AW(32), .DW(32), .TIMEOUT(4))  dut4 (.clk(clk), .rst(rst), .bus(b));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h required %h", n, act, exp);
        end
    endtask

    task automatic serve(input vec_t t);
        a.dm_req   = t.dm;
        a.dm_we    = t.we;
        a.dm_addr  = t.daddr;
        a.dm_wdata = t.wdata;
        a.if_req   = t.ifr;
        a.if_addr  = t.iaddr;
        @(negedge clk);
        chk("grant_req", a.mem_req, 1);
        chk("grant_we", a.mem_we, t.exp_we);
        chk("grant_addr", a.mem_addr, t.exp_addr);
        chk("grant_wdata", a.mem_wdata, t.exp_wdata);
        chk("busy_stall", a.stall_if, t.ifr);
        for (int i = 0; i < t.dly; i++) begin
            @(negedge clk);
            chk("wait_req", a.mem_req, 1);
            chk("wait_addr", a.mem_addr, t.exp_addr);
            chk("wait_ready", {a.if_ready, a.dm_ready}, 0);
        end
        a.mem_ack   = 1'b1;
        a.mem_rdata = t.rdata;
        @(negedge clk);
        a.mem_ack   = 1'b0;
        a.mem_rdata = 32'hFFFF_FFFF;
        chk("ready", {a.if_ready, a.dm_ready}, t.exp_d ? 2'b01 : 2'b10);
        chk("rdata", t.exp_d ? a.dm_rdata : a.if_rdata, t.exp_rdata);
        chk("err", {a.if_err, a.dm_err}, 0);
        chk("resp_req", a.mem_req, 0);
        chk("resp_stall", a.stall_if, t.ifr && t.exp_d);
        if (t.exp_d) a.dm_req = 1'b0;
        else         a.if_req = 1'b0;
        @(negedge clk);
        chk("idle", {a.mem_req, a.if_ready, a.dm_ready}, 0);
    endtask

    task automatic tmo(input logic ack4);
        b.if_req  = 1'b1;
        b.if_addr = 32'h80;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("tmo_req", b.mem_req, 1);
            chk("tmo_ready", b.if_ready, 0);
        end
        b.mem_ack   = ack4;
        b.mem_rdata = 32'h5555_AAAA;
        @(negedge clk);
        b.mem_ack = 1'b0;
        chk("tmo_drop", b.mem_req, 0);
        chk("tmo_ifready", b.if_ready, 1);
        chk("tmo_err", b.if_err, !ack4);
        chk("tmo_rdata", b.if_rdata, ack4 ? 32'h5555_AAAA : 32'h0);
        b.if_req = 1'b0;
        @(negedge clk);
        chk("tmo_idle", {b.mem_req, b.if_ready}, 0);
    endtask

    initial begin
        v[0] = '{1'b0, 1'b0, 32'h0,   32'h0,        1'b1, 32'h40, 0, 32'h0050_0093, 1'b0, 1'b0, 32'h40,  32'h0,        32'h0050_0093};
        v[1] = '{1'b1, 1'b1, 32'h100, 32'hDEAD_BEEF, 1'b1, 32'h44, 0, 32'hAAAA_AAAA, 1'b1, 1'b1, 32'h100, 32'hDEAD_BEEF, 32'h0};
        v[2] = '{1'b0, 1'b0, 32'h0,   32'h0,        1'b1, 32'h44, 0, 32'h1111_1111, 1'b0, 1'b0, 32'h44,  32'h0,        32'h1111_1111};
        v[3] = '{1'b1, 1'b0, 32'h200, 32'h77,       1'b0, 32'h0,  5, 32'h1234_5678, 1'b1, 1'b0, 32'h200, 32'h77,       32'h1234_5678};
        v[4] = '{1'b1, 1'b0, 32'h300, 32'h0,        1'b0, 32'h0,  2, 32'hCAFE_F00D, 1'b1, 1'b0, 32'h300, 32'h0,        32'hCAFE_F00D};
        v[5] = '{1'b0, 1'b0, 32'h0,   32'h0,        1'b1, 32'h48, 1, 32'h0BAD_C0DE, 1'b0, 1'b0, 32'h48,  32'h0,        32'h0BAD_C0DE};
        tests = 0;
        fails = 0;
        rst = 1'b0;
        {a.if_req, a.dm_req, a.dm_we, a.mem_ack} = '0;
        {a.if_addr, a.dm_addr, a.dm_wdata, a.mem_rdata} = '0;
        {b.if_req, b.dm_req, b.dm_we, b.mem_ack} = '0;
        {b.if_addr, b.dm_addr, b.dm_wdata, b.mem_rdata} = '0;
        repeat (2) @(negedge clk);
        chk("rst_mem_ctl", {a.mem_req, a.mem_we}, 0);
        chk("rst_mem_addr", a.mem_addr, 0);
        chk("rst_mem_wdata", a.mem_wdata, 0);
        chk("rst_flags", {a.if_ready, a.dm_ready, a.if_err, a.dm_err}, 0);
        chk("rst_if_rdata", a.if_rdata, 0);
        chk("rst_dm_rdata", a.dm_rdata, 0);
        rst = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 5; i++) serve(v[i]);
        a.mem_ack   = 1'b1;
        a.mem_rdata = 32'h9999_9999;
        @(negedge clk);
        a.mem_ack = 1'b0;
        chk("spur_ready", {a.if_ready, a.dm_ready, a.mem_req}, 0);
        @(negedge clk);
        chk("spur_after", {a.if_ready, a.dm_ready, a.mem_req}, 0);
        chk("spur_rdata", a.dm_rdata, 32'hCAFE_F00D);
        tmo(1'b0);
        tmo(1'b1);
        a.dm_req  = 1'b1;
        a.dm_we   = 1'b0;
        a.dm_addr = 32'h400;
        @(negedge clk);
        chk("rstmid_req", a.mem_req, 1);
        #2 rst = 1'b0;
        #1 chk("rstmid_async", a.mem_req, 0);
        @(negedge clk);
        chk("rstmid_noready", a.dm_ready, 0);
        a.dm_req = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("rstmid_idle", {a.mem_req, a.dm_ready, a.if_ready}, 0);
        serve(v[5]);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
